regfile_mp: RTL
===============

# regfile_mp

Parametrised multi-read-port register file for the MIPS datapath, succeeding the fixed 32x32 two-read-port file. It has N_RD registered read ports, one write port, write-first bypass, an optional hardwired-zero entry 0, and a built-in clear sequencer. The sequencer zeroes every entry after reset or on request, so no simulation-only memory initialisation is needed. It sits between decode (read addresses) and writeback (write port).

## Interface
- DATA_W, 32, width of each register
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries
- N_RD, 2, number of read ports (1..4)
- ZERO_REG, 1, 1 = entry 0 reads as 0 and ignores writes
- clk  in  1  single clock; all state changes on posedge
- rst_n  in  1  reset, asynchronous assert, active-low
- rd_addr  in  N_RD*ADDR_W  packed read addresses; port i at bits [i*ADDR_W +: ADDR_W]
- rd_data  out  N_RD*DATA_W  packed registered read data, same packing
- wr_en  in  1  write strobe
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- clr_req  in  1  single-cycle request to re-zero the whole file
- busy  out  1  high while the clear sequence runs

## Operation
- FSM states: CLEAR and READY.
  - rst_n low forces CLEAR, clear counter = 0, rd_data = 0, busy = 1.
- CLEAR:
  - Each posedge writes 0 to entry[counter], then increments the counter.
  - On the posedge that writes entry DEPTH-1, go to READY and drop busy.
  - wr_en is ignored; no write is lost silently, because writeback must stall on busy.
  - Every rd_data port is loaded with 0 each cycle.
  - clr_req is ignored.
- READY:
  - When wr_en=1, entry[wr_addr] <= wr_data.
  - Exception: when ZERO_REG=1 and wr_addr==0, the write is dropped.
  - clr_req=1 goes to CLEAR with counter=0. A write in that same cycle is still performed, then cleared in turn.
- Read, per port i, at every posedge in READY:
  - ZERO_REG=1 and rd_addr_i==0 -> 0.
  - Else, wr_en=1 and wr_addr==rd_addr_i -> wr_data (write-first bypass).
  - Else -> entry[rd_addr_i].
- Multiple ports reading the same address each receive identical data.
- Counter width is ADDR_W+1. Wrap-around of the counter is never relied on.

## Timing
- Read latency: 1 cycle. rd_addr sampled at edge k produces rd_data valid after edge k.
- Write latency: the entry is updated at the sampling edge. A read of the same address at the same edge sees the new value via bypass.
- Clear duration: exactly DEPTH posedges after rst_n deasserts, or after the clr_req edge. busy is low from the edge that writes the last entry.
- Reset mid-clear or mid-write: asynchronously aborts it. The sequence restarts from entry 0 on release.
- Reset values: rd_data = 0, busy = 1, state = CLEAR, counter = 0. Array contents are undefined until the clear completes.

## Structure
- Package regfile_pkg holds:
  - state enum (ST_CLEAR, ST_READY)
  - default DATA_W / ADDR_W / N_RD constants
  - helper function for packed-port slicing
- Sub-module regfile_clear_seq holds the FSM, counter and busy. It outputs clear write enable and address to the array mux.
- Top level holds the array, write mux (clear vs. port), and N_RD generate-loop read ports with bypass and zero logic.

## Test plan
- Reset release with defaults: busy stays high for 32 cycles, then low. All 32 addresses read 0x00000000 on both ports.
- Write 0xDEADBEEF to r5, then read r5 next cycle: rd_data = 0xDEADBEEF with 1-cycle latency.
- Same cycle: wr r7 = 0x12345678 and port0 reads r7, port1 reads r7 -> both return 0x12345678 after that edge, without waiting a cycle.
- ZERO_REG=1: write 0xFFFFFFFF to r0, then read r0 -> 0. With ZERO_REG=0 the same sequence -> 0xFFFFFFFF.
- Fill r1..r31 with nonzero values, pulse clr_req together with wr r3=0xAA:
  - busy is high for 32 cycles.
  - Writes issued while busy are dropped.
  - Afterwards all entries read 0.
- Assert rst_n at clear count 10, release: busy again lasts 32 full cycles. Rerun with N_RD=4, DATA_W=16, ADDR_W=3: busy lasts 8 cycles, and 4 independent reads return the correct values.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and defaults for the multi-read-port register file.
// The helper gives the low bit of a port's field inside a packed bus.
package regfile_pkg;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_N_RD   = 2;

  function automatic int port_lsb(input int port, input int width);
    return port * width;
  endfunction

endpackage

// File: rtl/regfile_clear_seq.sv
// Clear sequencer: walks every entry once after reset or on clr_req.
// It drives the array's clear write port and the busy flag.
module regfile_clear_seq
  import regfile_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_req,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr,
  output logic              busy
);

  localparam int CNT_W = ADDR_W + 1;
  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEPTH - 1);

  state_t           state_r;
  state_t           state_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_s;
  logic             busy_r;

  // State, counter and registered busy flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_CLEAR;
      cnt_r   <= {CNT_W{1'b0}};
      busy_r  <= 1'b1;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      busy_r  <= (state_s == ST_CLEAR);
    end
  end

  // Next state: leave CLEAR on the edge that zeroes the last entry
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    case (state_r)
      ST_CLEAR: begin
        cnt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        if (cnt_r == CNT_LAST) begin
          state_s = ST_READY;
        end else begin
          state_s = ST_CLEAR;
        end
      end
      ST_READY: begin
        if (clr_req) begin
          state_s = ST_CLEAR;
          cnt_s   = {CNT_W{1'b0}};
        end else begin
          state_s = ST_READY;
        end
      end
      default: begin
        state_s = ST_CLEAR;
        cnt_s   = {CNT_W{1'b0}};
      end
    endcase
  end

  // Outputs towards the array write mux
  always_comb begin
    clr_we   = (state_r == ST_CLEAR);
    clr_addr = cnt_r[ADDR_W-1:0];
    busy     = busy_r;
  end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised register file: N_RD registered read ports with write-first
// bypass, one write port, optional hardwired-zero entry 0, self-clearing.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int N_RD     = DEF_N_RD,
  parameter int ZERO_REG = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_RD*ADDR_W-1:0] rd_addr,
  output logic [N_RD*DATA_W-1:0] rd_data,
  input  logic                   wr_en,
  input  logic [ADDR_W-1:0]      wr_addr,
  input  logic [DATA_W-1:0]      wr_data,
  input  logic                   clr_req,
  output logic                   busy
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic              clr_we_s;
  logic [ADDR_W-1:0] clr_addr_s;
  logic              port_we_s;
  logic              mem_we_s;
  logic [ADDR_W-1:0] mem_waddr_s;
  logic [DATA_W-1:0] mem_wdata_s;

  regfile_clear_seq #(
    .ADDR_W (ADDR_W)
  ) u_clear_seq (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_req  (clr_req),
    .clr_we   (clr_we_s),
    .clr_addr (clr_addr_s),
    .busy     (busy)
  );

  // Write mux: the clear sequencer owns the array while it runs
  always_comb begin
    port_we_s = wr_en && !((ZERO_REG != 0) && (wr_addr == {ADDR_W{1'b0}}));
    if (clr_we_s) begin
      mem_we_s    = 1'b1;
      mem_waddr_s = clr_addr_s;
      mem_wdata_s = {DATA_W{1'b0}};
    end else begin
      mem_we_s    = port_we_s;
      mem_waddr_s = wr_addr;
      mem_wdata_s = wr_data;
    end
  end

  // Storage array, deliberately without reset
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_r[mem_waddr_s] <= mem_wdata_s;
    end
  end

  for (genvar gi = 0; gi < N_RD; gi++) begin : g_rd
    logic [ADDR_W-1:0] ra_s;
    logic [DATA_W-1:0] rd_s;
    logic [DATA_W-1:0] rd_r;

    // Read select: clear, zero entry, bypass, then array
    always_comb begin
      ra_s = rd_addr[port_lsb(gi, ADDR_W) +: ADDR_W];
      if (clr_we_s) begin
        rd_s = {DATA_W{1'b0}};
      end else if ((ZERO_REG != 0) && (ra_s == {ADDR_W{1'b0}})) begin
        rd_s = {DATA_W{1'b0}};
      end else if (wr_en && (wr_addr == ra_s)) begin
        rd_s = wr_data;
      end else begin
        rd_s = mem_r[ra_s];
      end
    end

    // Registered read data
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rd_r <= {DATA_W{1'b0}};
      end else begin
        rd_r <= rd_s;
      end
    end

    assign rd_data[port_lsb(gi, DATA_W) +: DATA_W] = rd_r;
  end

endmodule
